// File: rtl/fetch_pc_ctrl.sv
// Fetch PC sequencer: owns the architectural fetch PC, advances it by 4,
// holds it on stall, and redirects it to resolved branch/jump targets.
// Squashes wrong-path fetch/decode work (kill_fd) and parks a redirect that
// arrives during a stall until the stall releases. It also keeps a count of
// applied redirects and a sticky flag for misaligned targets.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h4000_0000,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  output logic [31:0]      pc,
  output logic [31:0]      next_pc,
  output logic             fetch_valid,
  output logic             kill_fd,
  output logic             misalign,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_HOLD  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  // The flush counter is three bits wide, which covers FLUSH_CYCLES up to 7.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam bit         HAS_FLUSH  = (FLUSH_CYCLES != 0);

  // Architectural state
  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       pend_q, pend_d;
  logic              pend_valid_q, pend_valid_d;
  logic [2:0]        flush_cnt_q, flush_cnt_d;
  logic              misalign_q, misalign_d;
  logic [CNT_W-1:0]  redirect_cnt_q, redirect_cnt_d;

  // Per-cycle decisions produced by the FSM and consumed by the datapath
  logic              apply_en;    // a redirect target is written into pc this edge
  logic [31:0]       apply_raw;   // raw (unaligned) target being applied
  logic              latch_en;    // a redirect is parked in pend this edge
  logic              advance_en;  // sequential pc+4 this edge
  logic              flush_dec;   // one flush cycle consumed this edge
  logic              fetch_valid_c;
  logic              kill_fd_c;

  // FSM next-state and control outputs; priority is redirect > stall > sequential
  always_comb begin
    state_d       = state_q;
    apply_en      = 1'b0;
    apply_raw     = redirect_target;
    latch_en      = 1'b0;
    advance_en    = 1'b0;
    flush_dec     = 1'b0;
    fetch_valid_c = 1'b0;
    kill_fd_c     = 1'b0;

    unique case (state_q)
      S_BOOT: begin
        // pc already holds RESET_PC; the first real fetch happens in RUN.
        // Redirects arriving here are ignored.
        state_d = S_RUN;
      end

      S_RUN, S_FLUSH: begin
        fetch_valid_c = 1'b1;
        kill_fd_c     = (state_q == S_FLUSH);
        if (redirect_valid && !stall) begin
          apply_en  = 1'b1;
          kill_fd_c = 1'b1;
          state_d   = HAS_FLUSH ? S_FLUSH : S_RUN;
        end else if (redirect_valid) begin
          // Cannot move pc while stalled: park the target and keep squashing.
          latch_en  = 1'b1;
          kill_fd_c = 1'b1;
          state_d   = S_HOLD;
        end else if (!stall) begin
          advance_en = 1'b1;
          if (state_q == S_FLUSH) begin
            flush_dec = 1'b1;
            if (flush_cnt_q <= 3'd1) begin
              state_d = S_RUN;
            end
          end
        end
      end

      S_HOLD: begin
        fetch_valid_c = 1'b1;
        kill_fd_c     = 1'b1;
        if (stall) begin
          // Latest redirect wins while we wait for the stall to drop.
          latch_en = redirect_valid;
        end else if (redirect_valid || pend_valid_q) begin
          apply_en  = 1'b1;
          apply_raw = redirect_valid ? redirect_target : pend_q;
          state_d   = HAS_FLUSH ? S_FLUSH : S_RUN;
        end else begin
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // Datapath next values: pc, pending target, flush counter, flag and counter
  always_comb begin
    pc_d           = pc_q;
    pend_d         = pend_q;
    pend_valid_d   = pend_valid_q;
    flush_cnt_d    = flush_cnt_q;
    misalign_d     = misalign_q;
    redirect_cnt_d = redirect_cnt_q;

    if (state_q == S_BOOT) begin
      pc_d = RESET_PC;
    end else if (apply_en) begin
      // Targets are always word aligned in the PC; low bits only feed the flag.
      pc_d = {apply_raw[31:2], 2'b00};
    end else if (advance_en) begin
      pc_d = pc_q + 32'd4;
    end

    if (latch_en) begin
      pend_d       = redirect_target;
      pend_valid_d = 1'b1;
    end else if (apply_en) begin
      pend_valid_d = 1'b0;
    end

    if (apply_en) begin
      flush_cnt_d = FLUSH_LOAD;
    end else if (flush_dec) begin
      flush_cnt_d = flush_cnt_q - 3'd1;
    end

    if (apply_en && (apply_raw[1:0] != 2'b00)) begin
      misalign_d = 1'b1;
    end
    if (latch_en && (redirect_target[1:0] != 2'b00)) begin
      misalign_d = 1'b1;
    end

    // Count applied redirects only; overwriting a parked target is not counted.
    if (apply_en) begin
      redirect_cnt_d = redirect_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State registers with synchronous reset; reset drops pending and flush work
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_BOOT;
      pc_q           <= RESET_PC;
      pend_q         <= 32'd0;
      pend_valid_q   <= 1'b0;
      flush_cnt_q    <= 3'd0;
      misalign_q     <= 1'b0;
      redirect_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      pend_q         <= pend_d;
      pend_valid_q   <= pend_valid_d;
      flush_cnt_q    <= flush_cnt_d;
      misalign_q     <= misalign_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign pc           = pc_q;
  assign next_pc      = pc_d;
  assign fetch_valid  = fetch_valid_c;
  assign kill_fd      = kill_fd_c;
  assign misalign     = misalign_q;
  assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: one task per scenario, inline checks,
// one summary line at the end.
module tb_fetch_pc_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        fetch_valid;
  logic        kill_fd;
  logic        misalign;
  logic [31:0] redirect_cnt;

  int tests_run;
  int tests_failed;

  fetch_pc_ctrl #(
    .RESET_PC     (32'h4000_0000),
    .FLUSH_CYCLES (1),
    .CNT_W        (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc              (pc),
    .next_pc         (next_pc),
    .fetch_valid     (fetch_valid),
    .kill_fd         (kill_fd),
    .misalign        (misalign),
    .redirect_cnt    (redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are changed afterwards.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Plan 1: reset, BOOT, then sequential fetch
  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    cyc(); cyc();
    rst = 1'b0; #1;
    tests_run++; if (pc !== 32'h4000_0000) begin tests_failed++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h4000_0000); end
    tests_run++; if (fetch_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_fetch_valid got=%b exp=0", fetch_valid); end
    tests_run++; if (kill_fd !== 1'b0) begin tests_failed++; $display("FAIL reset_kill got=%b exp=0", kill_fd); end
    tests_run++; if (next_pc !== 32'h4000_0000) begin tests_failed++; $display("FAIL reset_next_pc got=%h exp=%h", next_pc, 32'h4000_0000); end
    tests_run++; if (redirect_cnt !== 32'd0) begin tests_failed++; $display("FAIL reset_cnt got=%0d exp=0", redirect_cnt); end
    tests_run++; if (misalign !== 1'b0) begin tests_failed++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
    cyc();
    tests_run++; if (pc !== 32'h4000_0000 || fetch_valid !== 1'b1) begin tests_failed++; $display("FAIL run_first pc=%h fv=%b exp pc=%h fv=1", pc, fetch_valid, 32'h4000_0000); end
    tests_run++; if (next_pc !== 32'h4000_0004) begin tests_failed++; $display("FAIL run_first_next got=%h exp=%h", next_pc, 32'h4000_0004); end
    cyc();
    tests_run++; if (pc !== 32'h4000_0004) begin tests_failed++; $display("FAIL run_seq1 got=%h exp=%h", pc, 32'h4000_0004); end
    cyc();
    tests_run++; if (pc !== 32'h4000_0008 || fetch_valid !== 1'b1 || redirect_cnt !== 32'd0) begin tests_failed++; $display("FAIL run_seq2 pc=%h fv=%b cnt=%0d exp pc=%h fv=1 cnt=0", pc, fetch_valid, redirect_cnt, 32'h4000_0008); end
    $display("[TB] test_reset done pc=%h", pc);
  endtask

  // Plan 2: redirect in RUN with one flush cycle
  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_target = 32'h4000_0100; #1;
    tests_run++; if (kill_fd !== 1'b1 || next_pc !== 32'h4000_0100) begin tests_failed++; $display("FAIL redir_cycle kill=%b next=%h exp kill=1 next=%h", kill_fd, next_pc, 32'h4000_0100); end
    cyc();
    redirect_valid = 1'b0; #1;
    tests_run++; if (pc !== 32'h4000_0100 || kill_fd !== 1'b1) begin tests_failed++; $display("FAIL redir_flush pc=%h kill=%b exp pc=%h kill=1", pc, kill_fd, 32'h4000_0100); end
    tests_run++; if (redirect_cnt !== 32'd1) begin tests_failed++; $display("FAIL redir_cnt got=%0d exp=1", redirect_cnt); end
    cyc();
    tests_run++; if (pc !== 32'h4000_0104 || kill_fd !== 1'b0) begin tests_failed++; $display("FAIL redir_after pc=%h kill=%b exp pc=%h kill=0", pc, kill_fd, 32'h4000_0104); end
    $display("[TB] test_redirect done pc=%h cnt=%0d", pc, redirect_cnt);
  endtask

  // Plan 3: redirects during a three-cycle stall, latest wins, counted once
  task automatic test_stall_redirect();
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h4000_0200; #1;
    tests_run++; if (kill_fd !== 1'b1 || next_pc !== 32'h4000_0104) begin tests_failed++; $display("FAIL stall_redir1 kill=%b next=%h exp kill=1 next=%h", kill_fd, next_pc, 32'h4000_0104); end
    cyc();
    redirect_target = 32'h4000_0300; #1;
    tests_run++; if (pc !== 32'h4000_0104 || kill_fd !== 1'b1 || next_pc !== 32'h4000_0104) begin tests_failed++; $display("FAIL stall_redir2 pc=%h kill=%b next=%h exp pc=%h kill=1", pc, kill_fd, next_pc, 32'h4000_0104); end
    cyc();
    redirect_valid = 1'b0; #1;
    tests_run++; if (pc !== 32'h4000_0104 || kill_fd !== 1'b1 || redirect_cnt !== 32'd1) begin tests_failed++; $display("FAIL stall_hold pc=%h kill=%b cnt=%0d exp pc=%h kill=1 cnt=1", pc, kill_fd, redirect_cnt, 32'h4000_0104); end
    cyc();
    stall = 1'b0; #1;
    tests_run++; if (next_pc !== 32'h4000_0300 || kill_fd !== 1'b1) begin tests_failed++; $display("FAIL stall_release next=%h kill=%b exp next=%h kill=1", next_pc, kill_fd, 32'h4000_0300); end
    cyc();
    tests_run++; if (pc !== 32'h4000_0300 || redirect_cnt !== 32'd2 || kill_fd !== 1'b1) begin tests_failed++; $display("FAIL stall_applied pc=%h cnt=%0d kill=%b exp pc=%h cnt=2 kill=1", pc, redirect_cnt, kill_fd, 32'h4000_0300); end
    cyc();
    tests_run++; if (pc !== 32'h4000_0304 || kill_fd !== 1'b0) begin tests_failed++; $display("FAIL stall_after pc=%h kill=%b exp pc=%h kill=0", pc, kill_fd, 32'h4000_0304); end
    $display("[TB] test_stall_redirect done pc=%h cnt=%0d", pc, redirect_cnt);
  endtask

  // Plan 4: misaligned target is aligned, flag is sticky until reset
  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_target = 32'h4000_0042; #1;
    tests_run++; if (next_pc !== 32'h4000_0040 || misalign !== 1'b0) begin tests_failed++; $display("FAIL mis_next next=%h mis=%b exp next=%h mis=0", next_pc, misalign, 32'h4000_0040); end
    cyc();
    redirect_valid = 1'b0; #1;
    tests_run++; if (pc !== 32'h4000_0040 || misalign !== 1'b1 || redirect_cnt !== 32'd3) begin tests_failed++; $display("FAIL mis_set pc=%h mis=%b cnt=%0d exp pc=%h mis=1 cnt=3", pc, misalign, redirect_cnt, 32'h4000_0040); end
    cyc();
    redirect_valid = 1'b1; redirect_target = 32'h4000_0080; #1;
    cyc();
    redirect_valid = 1'b0; #1;
    tests_run++; if (pc !== 32'h4000_0080 || misalign !== 1'b1 || redirect_cnt !== 32'd4) begin tests_failed++; $display("FAIL mis_sticky pc=%h mis=%b cnt=%0d exp pc=%h mis=1 cnt=4", pc, misalign, redirect_cnt, 32'h4000_0080); end
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; #1;
    tests_run++; if (misalign !== 1'b0 || redirect_cnt !== 32'd0 || pc !== 32'h4000_0000 || fetch_valid !== 1'b0) begin tests_failed++; $display("FAIL mis_clear mis=%b cnt=%0d pc=%h fv=%b exp mis=0 cnt=0 pc=%h fv=0", misalign, redirect_cnt, pc, fetch_valid, 32'h4000_0000); end
    cyc();
    $display("[TB] test_misalign done pc=%h", pc);
  endtask

  // Plan 5: sequential fetch wraps modulo 2^32
  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFF8; #1;
    cyc();
    redirect_valid = 1'b0; #1;
    tests_run++; if (pc !== 32'hFFFF_FFF8 || next_pc !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_a pc=%h next=%h exp pc=%h next=%h", pc, next_pc, 32'hFFFF_FFF8, 32'hFFFF_FFFC); end
    cyc();
    tests_run++; if (pc !== 32'hFFFF_FFFC || next_pc !== 32'h0000_0000 || kill_fd !== 1'b0) begin tests_failed++; $display("FAIL wrap_b pc=%h next=%h kill=%b exp pc=%h next=0 kill=0", pc, next_pc, kill_fd, 32'hFFFF_FFFC); end
    cyc();
    tests_run++; if (pc !== 32'h0000_0000 || redirect_cnt !== 32'd1 || misalign !== 1'b0) begin tests_failed++; $display("FAIL wrap_c pc=%h cnt=%0d mis=%b exp pc=0 cnt=1 mis=0", pc, redirect_cnt, misalign); end
    $display("[TB] test_wrap done pc=%h", pc);
  endtask

  // Plan 6: reset in HOLD drops the parked target; BOOT ignores redirects
  task automatic test_reset_in_hold();
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h4000_0500; #1;
    cyc();
    redirect_valid = 1'b0; #1;
    tests_run++; if (kill_fd !== 1'b1 || pc !== 32'h0000_0000) begin tests_failed++; $display("FAIL hold_pre kill=%b pc=%h exp kill=1 pc=0", kill_fd, pc); end
    rst = 1'b1;
    cyc();
    rst = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h4000_0900; #1;
    tests_run++; if (pc !== 32'h4000_0000 || fetch_valid !== 1'b0 || kill_fd !== 1'b0 || next_pc !== 32'h4000_0000) begin tests_failed++; $display("FAIL hold_boot pc=%h fv=%b kill=%b next=%h exp pc=%h fv=0 kill=0", pc, fetch_valid, kill_fd, next_pc, 32'h4000_0000); end
    cyc();
    redirect_valid = 1'b0; #1;
    tests_run++; if (pc !== 32'h4000_0000 || kill_fd !== 1'b0 || next_pc !== 32'h4000_0000 || redirect_cnt !== 32'd0) begin tests_failed++; $display("FAIL hold_run_stall pc=%h kill=%b next=%h cnt=%0d exp pc=%h kill=0 cnt=0", pc, kill_fd, next_pc, redirect_cnt, 32'h4000_0000); end
    stall = 1'b0; #1;
    tests_run++; if (next_pc !== 32'h4000_0004 || kill_fd !== 1'b0) begin tests_failed++; $display("FAIL hold_no_pend next=%h kill=%b exp next=%h kill=0", next_pc, kill_fd, 32'h4000_0004); end
    cyc();
    cyc();
    tests_run++; if (pc !== 32'h4000_0008 || redirect_cnt !== 32'd0) begin tests_failed++; $display("FAIL hold_seq pc=%h cnt=%0d exp pc=%h cnt=0", pc, redirect_cnt, 32'h4000_0008); end
    $display("[TB] test_reset_in_hold done pc=%h", pc);
  endtask

  // Stall during FLUSH holds both pc and the flush counter
  task automatic test_flush_stall();
    redirect_valid = 1'b1; redirect_target = 32'h4000_0800; #1;
    cyc();
    redirect_valid = 1'b0; stall = 1'b1; #1;
    tests_run++; if (pc !== 32'h4000_0800 || kill_fd !== 1'b1 || next_pc !== 32'h4000_0800) begin tests_failed++; $display("FAIL fstall_a pc=%h kill=%b next=%h exp pc=%h kill=1", pc, kill_fd, next_pc, 32'h4000_0800); end
    cyc();
    stall = 1'b0; #1;
    tests_run++; if (pc !== 32'h4000_0800 || kill_fd !== 1'b1 || next_pc !== 32'h4000_0804) begin tests_failed++; $display("FAIL fstall_b pc=%h kill=%b next=%h exp pc=%h kill=1 next=%h", pc, kill_fd, next_pc, 32'h4000_0800, 32'h4000_0804); end
    cyc();
    tests_run++; if (pc !== 32'h4000_0804 || kill_fd !== 1'b0 || redirect_cnt !== 32'd1) begin tests_failed++; $display("FAIL fstall_c pc=%h kill=%b cnt=%0d exp pc=%h kill=0 cnt=1", pc, kill_fd, redirect_cnt, 32'h4000_0804); end
    $display("[TB] test_flush_stall done pc=%h", pc);
  endtask

  // Redirect in consecutive cycles: second one lands during FLUSH
  task automatic test_back_to_back();
    redirect_valid = 1'b1; redirect_target = 32'h4000_0600; #1;
    cyc();
    redirect_target = 32'h4000_0700; #1;
    tests_run++; if (pc !== 32'h4000_0600 || kill_fd !== 1'b1 || next_pc !== 32'h4000_0700) begin tests_failed++; $display("FAIL b2b_a pc=%h kill=%b next=%h exp pc=%h kill=1 next=%h", pc, kill_fd, next_pc, 32'h4000_0600, 32'h4000_0700); end
    cyc();
    redirect_valid = 1'b0; #1;
    tests_run++; if (pc !== 32'h4000_0700 || kill_fd !== 1'b1 || redirect_cnt !== 32'd3) begin tests_failed++; $display("FAIL b2b_b pc=%h kill=%b cnt=%0d exp pc=%h kill=1 cnt=3", pc, kill_fd, redirect_cnt, 32'h4000_0700); end
    cyc();
    tests_run++; if (pc !== 32'h4000_0704 || kill_fd !== 1'b0) begin tests_failed++; $display("FAIL b2b_c pc=%h kill=%b exp pc=%h kill=0", pc, kill_fd, 32'h4000_0704); end
    $display("[TB] test_back_to_back done pc=%h cnt=%0d", pc, redirect_cnt);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    test_reset();
    test_redirect();
    test_stall_redirect();
    test_misalign();
    test_wrap();
    test_reset_in_hold();
    test_flush_stall();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog timeout after %0d tests", tests_run);
    $fatal(1, "timeout");
  end

endmodule
